// File: rtl/alu_cmd_driver.sv
// Sequential front end for the combinational 8-bit ALU. It accepts tagged commands,
// holds the operands on the ALU for a settle window, then queues the results in order.
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_tag,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_enable,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_tag,
    output logic [2:0]  rsp_opcode,
    output logic        rsp_div0,
    output logic        busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ENT_W = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [3:0]         tag_q, tag_d;
    logic               div0_q, div0_d;

    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W:0]     count_q, count_d;

    logic               accept;
    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   head;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and ready depends only on registered state and soft_clear.
    assign cmd_ready = rst_n && !soft_clear && (state_q == S_IDLE) && (count_q != CNT_FULL);
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = (count_q != '0) && rsp_ready;

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign alu_enable = (state_q == S_DRIVE);

    assign head       = mem_q[rd_q];
    assign rsp_valid  = (count_q != '0);
    assign rsp_result = head[23:8];
    assign rsp_tag    = head[7:4];
    assign rsp_opcode = head[3:1];
    assign rsp_div0   = head[0];
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tag_d   = tag_q;
        div0_d  = div0_q;
        push    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_opcode;
                    tag_d   = cmd_tag;
                    div0_d  = (cmd_opcode == 3'b011) && (cmd_b == 8'h00);
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush drops the in-flight command; operand registers keep their last values.
        if (soft_clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            push    = 1'b0;
        end
    end

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;

        if (push) begin
            mem_d[wr_q] = {alu_result, tag_q, op_q, div0_q};
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (soft_clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            div0_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            div0_q  <= div0_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
endmodule
